vdp_reg_interface: RTL and testbench



---
 rtl/vdp_reg_interface_if.sv | 23 ++
 rtl/vdp_reg_interface.sv | 96 +++++++++
 tb/tb_vdp_reg_interface.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_reg_interface_if.sv
// CPU-side control/status port bundle of the VDP register block.
// The master drives the byte strobes and write data; the register block
// returns the combinational register-commit strobe.
interface vdp_reg_interface_if;
  logic       wr_tick;
  logic       rd_tick;
  logic [7:0] din;
  logic       update_vdp_reg_tick;

  modport master (
    output wr_tick,
    output rd_tick,
    output din,
    input  update_vdp_reg_tick
  );

  modport slave (
    input  wr_tick,
    input  rd_tick,
    input  din,
    output update_vdp_reg_tick
  );
endinterface

// File: rtl/vdp_reg_interface.sv
// VDP register write interface.
// Two-byte control-port sequence: byte 1 is data, byte 2 is 1xxxxnnn and
// commits the data byte into register nnn. A status read resets the byte
// toggle, mirroring the classic VDP behaviour.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_FIRST  | next control-port byte is a data byte
// ST_SECOND | data byte latched, next byte is a command byte
module vdp_reg_interface (
  input  logic                        clk,
  input  logic                        reset,
  vdp_reg_interface_if.slave          bus,
  output logic [7:0]                  r0,
  output logic [7:0]                  r1,
  output logic [7:0]                  r2,
  output logic [7:0]                  r3,
  output logic [7:0]                  r4,
  output logic [7:0]                  r5,
  output logic [7:0]                  r6,
  output logic [7:0]                  r7,
  output logic                        state_reg,
  output logic [7:0]                  w0_reg
);

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      w0_q, w0_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic            upd_tick;

  // Byte-toggle state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a status read always rewinds to the first byte and wins
  // over a simultaneous write; otherwise each written byte flips the toggle.
  always_comb begin
    state_d = state_q;
    if (bus.rd_tick) begin
      state_d = ST_FIRST;
    end else if (bus.wr_tick) begin
      state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_FIRST;
    end
  end

  // Commit strobe: command byte with bit 7 set arriving in the second slot.
  always_comb begin
    upd_tick = (state_q == ST_SECOND) && bus.wr_tick && bus.din[7] && !bus.rd_tick;
    bus.update_vdp_reg_tick = upd_tick;
  end

  // Data-byte latch and register-file next values.
  always_comb begin
    w0_d   = w0_q;
    regs_d = regs_q;
    if ((state_q == ST_FIRST) && bus.wr_tick && !bus.rd_tick) begin
      w0_d = bus.din;
    end
    if (upd_tick) begin
      regs_d[bus.din[2:0]] = w0_q;
    end
  end

  // Data-byte latch and register-file flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0_q   <= '0;
      regs_q <= '0;
    end else begin
      w0_q   <= w0_d;
      regs_q <= regs_d;
    end
  end

  assign state_reg = state_q;
  assign w0_reg    = w0_q;
  assign r0        = regs_q[0];
  assign r1        = regs_q[1];
  assign r2        = regs_q[2];
  assign r3        = regs_q[3];
  assign r4        = regs_q[4];
  assign r5        = regs_q[5];
  assign r6        = regs_q[6];
  assign r7        = regs_q[7];

endmodule

// File: tb/tb_vdp_reg_interface.sv
// Bench for vdp_reg_interface: directed scenarios plus a randomized run,
// all checked against a byte-level model of the control-port protocol.
module tb_vdp_reg_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic       state_reg;
  logic [7:0] w0_reg;
  logic [7:0] dut_r [8];

  always #5 clk = ~clk;

  vdp_reg_interface_if bus_if ();

  vdp_reg_interface dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .r5        (r5),
    .r6        (r6),
    .r7        (r7),
    .state_reg (state_reg),
    .w0_reg    (w0_reg)
  );

  always_comb begin
    dut_r[0] = r0; dut_r[1] = r1; dut_r[2] = r2; dut_r[3] = r3;
    dut_r[4] = r4; dut_r[5] = r5; dut_r[6] = r6; dut_r[7] = r7;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: register file, pending data byte, and "expecting second byte" flag.
  logic [7:0] m_r [8];
  logic [7:0] m_w0;
  logic       m_second;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_w0     = 8'h00;
    m_second = 1'b0;
  endtask

  function automatic logic model_commit();
    return m_second && bus_if.wr_tick && bus_if.din[7] && !bus_if.rd_tick;
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic [7:0] d);
    bus_if.wr_tick = wr;
    bus_if.rd_tick = rd;
    bus_if.din     = d;
    #1;
  endtask

  // One clock edge; the model consumes the byte presented on that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (bus_if.rd_tick) begin
        m_second = 1'b0;
      end else if (bus_if.wr_tick) begin
        if (!m_second) begin
          m_w0     = bus_if.din;
          m_second = 1'b1;
        end else begin
          if (bus_if.din[7]) m_r[bus_if.din[2:0]] = m_w0;
          m_second = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 8'h8F);
    #10;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_r[i] !== 8'h00) begin
        errors++; $display("FAIL reset_r%0d got %02h exp 00", i, dut_r[i]);
      end
    end
    checks++;
    if (state_reg !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", state_reg); end
    checks++;
    if (w0_reg !== 8'h00) begin errors++; $display("FAIL reset_w0 got %02h exp 00", w0_reg); end
    checks++;
    if (bus_if.update_vdp_reg_tick !== 1'b0) begin
      errors++; $display("FAIL reset_upd got %b exp 0", bus_if.update_vdp_reg_tick);
    end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    drive(1'b1, 1'b0, 8'hEE);
    tick();
    checks++;
    if (state_reg !== 1'b1) begin errors++; $display("FAIL basic_state1 got %b exp 1", state_reg); end
    checks++;
    if (w0_reg !== 8'hEE) begin errors++; $display("FAIL basic_w0 got %02h exp EE", w0_reg); end
    checks++;
    if (r0 !== 8'h00) begin errors++; $display("FAIL basic_r0_early got %02h exp 00", r0); end
    drive(1'b1, 1'b0, 8'h80);
    checks++;
    if (bus_if.update_vdp_reg_tick !== 1'b1) begin
      errors++; $display("FAIL basic_upd got %b exp 1", bus_if.update_vdp_reg_tick);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r0 !== 8'hEE) begin errors++; $display("FAIL basic_r0 got %02h exp EE", r0); end
    checks++;
    if (state_reg !== 1'b0) begin errors++; $display("FAIL basic_state0 got %b exp 0", state_reg); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (dut_r[i] !== 8'h00) begin errors++; $display("FAIL basic_other_r%0d got %02h exp 00", i, dut_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6];
    seq = '{8'h44, 8'h84, 8'h55, 8'h85, 8'h66, 8'h86};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, seq[i]);
      checks++;
      if (bus_if.update_vdp_reg_tick !== model_commit()) begin
        errors++; $display("FAIL b2b_upd byte %0d got %b exp %b", i, bus_if.update_vdp_reg_tick, model_commit());
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r4 !== 8'h44) begin errors++; $display("FAIL b2b_r4 got %02h exp 44", r4); end
    checks++;
    if (r5 !== 8'h55) begin errors++; $display("FAIL b2b_r5 got %02h exp 55", r5); end
    checks++;
    if (r6 !== 8'h66) begin errors++; $display("FAIL b2b_r6 got %02h exp 66", r6); end
    checks++;
    if (state_reg !== 1'b0) begin errors++; $display("FAIL b2b_state got %b exp 0", state_reg); end
    checks++;
    if (w0_reg !== 8'h66) begin errors++; $display("FAIL b2b_w0 got %02h exp 66", w0_reg); end
  endtask

  task automatic test_read_abort();
    drive(1'b1, 1'b0, 8'h22); tick();
    drive(1'b0, 1'b1, 8'h81); tick();
    checks++;
    if (state_reg !== 1'b0) begin errors++; $display("FAIL rdab_state got %b exp 0", state_reg); end
    checks++;
    if (w0_reg !== 8'h22) begin errors++; $display("FAIL rdab_w0 got %02h exp 22", w0_reg); end
    checks++;
    if (r1 !== 8'h00) begin errors++; $display("FAIL rdab_r1 got %02h exp 00", r1); end
    drive(1'b1, 1'b0, 8'h11); tick();
    drive(1'b1, 1'b0, 8'h81); tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r1 !== 8'h11) begin errors++; $display("FAIL rdab_r1_after got %02h exp 11", r1); end
    // Simultaneous strobes in the second slot: the read wins, no commit.
    drive(1'b1, 1'b0, 8'h99); tick();
    drive(1'b1, 1'b1, 8'h83);
    checks++;
    if (bus_if.update_vdp_reg_tick !== 1'b0) begin
      errors++; $display("FAIL simul_upd got %b exp 0", bus_if.update_vdp_reg_tick);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r3 !== 8'h00 || state_reg !== 1'b0) begin
      errors++; $display("FAIL simul_r3_state got %02h/%b exp 00/0", r3, state_reg);
    end
  endtask

  task automatic test_overwrite();
    drive(1'b1, 1'b0, 8'hF6); tick();
    drive(1'b1, 1'b0, 8'h86); tick();
    drive(1'b0, 1'b1, 8'h00); tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r6 !== 8'hF6) begin errors++; $display("FAIL ovw_r6 got %02h exp F6", r6); end
    checks++;
    if (state_reg !== 1'b0 || w0_reg !== 8'hF6) begin
      errors++; $display("FAIL ovw_rd_state_w0 got %b/%02h exp 0/F6", state_reg, w0_reg);
    end
    // Second byte with bit 7 clear is an address setup: toggle resets, nothing written.
    drive(1'b1, 1'b0, 8'h5A); tick();
    drive(1'b1, 1'b0, 8'h06); tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r6 !== 8'hF6 || state_reg !== 1'b0) begin
      errors++; $display("FAIL addr_setup r6/state got %02h/%b exp F6/0", r6, state_reg);
    end
  endtask

  task automatic test_idle_and_reset();
    drive(1'b1, 1'b0, 8'h77); tick();
    drive(1'b0, 1'b0, 8'h00);
    tick(); tick(); tick();
    // din[6:3] are don't-care in the command byte.
    drive(1'b1, 1'b0, 8'hFF);
    checks++;
    if (bus_if.update_vdp_reg_tick !== 1'b1) begin
      errors++; $display("FAIL idle_upd got %b exp 1", bus_if.update_vdp_reg_tick);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r7 !== 8'h77) begin errors++; $display("FAIL idle_r7 got %02h exp 77", r7); end
    drive(1'b1, 1'b0, 8'h3C); tick();
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_r[i] !== 8'h00) begin errors++; $display("FAIL midrst_r%0d got %02h exp 00", i, dut_r[i]); end
    end
    checks++;
    if (state_reg !== 1'b0 || w0_reg !== 8'h00) begin
      errors++; $display("FAIL midrst_state_w0 got %b/%02h exp 0/00", state_reg, w0_reg);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    drive(1'b1, 1'b0, 8'h33); tick();
    checks++;
    if (state_reg !== 1'b1 || w0_reg !== 8'h33) begin
      errors++; $display("FAIL postrst_first got %b/%02h exp 1/33", state_reg, w0_reg);
    end
    drive(1'b1, 1'b0, 8'h82); tick();
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (r2 !== 8'h33) begin errors++; $display("FAIL postrst_r2 got %02h exp 33", r2); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       wr, rd;
    for (int n = 0; n < 1500; n++) begin
      wr = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) == 0);
      d  = 8'($urandom);
      drive(wr, rd, d);
      checks++;
      if (bus_if.update_vdp_reg_tick !== model_commit()) begin
        errors++; $display("FAIL rnd_upd cyc %0d got %b exp %b", n, bus_if.update_vdp_reg_tick, model_commit());
      end
      tick();
      checks++;
      if (state_reg !== m_second || w0_reg !== m_w0) begin
        errors++; $display("FAIL rnd_state_w0 cyc %0d got %b/%02h exp %b/%02h", n, state_reg, w0_reg, m_second, m_w0);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dut_r[i] !== m_r[i]) begin
          errors++; $display("FAIL rnd_r%0d cyc %0d got %02h exp %02h", i, n, dut_r[i], m_r[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus_if.wr_tick = 1'b0;
    bus_if.rd_tick = 1'b0;
    bus_if.din     = 8'h00;
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_read_abort();
    test_overwrite();
    test_idle_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
